// File: rtl/nibble_pair_rx.sv
// nibble_pair_rx: serial-to-parallel receiver for an 8-bit frame laid out as a
// 2x4 packed array. Frames start on s_sof, are assembled bit by bit, then held
// for the consumer until word_ready. Unknown (x/z) input bits are preserved
// and flagged per element; status counters track unknown frames and aborts.
module nibble_pair_rx #(
    parameter int CNT_W     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic              s_data,
    input  logic              s_sof,
    output logic              s_ready,
    output logic [0:1][0:3]   word,
    output logic [0:1][0:3]   word_unk,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  unk_frames,
    output logic [CNT_W-1:0]  abort_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t          state;
    logic [2:0]      count;
    logic [0:1][0:3] frame;        // frame under assembly; word only updates on completion
    logic [0:1][0:3] frame_next;
    logic [0:1][0:3] unk_next;
    logic [2:0]      wr_pos;
    logic            valid_ok;
    logic            sof_ok;
    logic            wr_ok;
    logic            take;
    logic            restart;

    // x/z on the control inputs must behave as a deasserted 0
    assign valid_ok = (s_valid === 1'b1);
    assign sof_ok   = (s_sof === 1'b1);
    assign wr_ok    = (word_ready === 1'b1);

    // Both outputs decode straight from the state register so an async
    // reset is visible at once, without waiting for a clock edge
    assign s_ready    = (state != HOLD);
    assign word_valid = (state == HOLD);

    assign take    = valid_ok && (state != HOLD);
    assign restart = take && sof_ok;
    assign wr_pos  = restart ? 3'd0 : count;

    // Per-position write steering; the element a position lands in depends on
    // the arrival order. A restart also wipes the unknown flags of the old frame.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pos
            localparam int ROW = (LSB_FIRST != 0) ? (1 - gi / 4) : (gi / 4);
            localparam int COL = (LSB_FIRST != 0) ? (3 - gi % 4) : (gi % 4);
            logic hit;
            assign hit = (wr_pos == 3'(gi));
            assign frame_next[ROW][COL] = hit ? s_data : frame[ROW][COL];
            assign unk_next[ROW][COL]   = hit ? $isunknown(s_data)
                                              : (!restart && word_unk[ROW][COL]);
        end
    endgenerate

    // Receive FSM: collect bits, publish the frame, count aborts and unknown frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            frame      <= '0;
            word       <= '0;
            word_unk   <= '0;
            unk_frames <= '0;
            abort_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (restart) begin
                        frame    <= frame_next;
                        word_unk <= unk_next;
                        count    <= 3'd1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        frame    <= frame_next;
                        word_unk <= unk_next;
                        if (sof_ok) begin
                            count <= 3'd1;
                            if (abort_cnt != {CNT_W{1'b1}})
                                abort_cnt <= abort_cnt + CNT_W'(1);
                        end else if (count == 3'd7) begin
                            word  <= frame_next;
                            count <= 3'd0;
                            state <= HOLD;
                        end else begin
                            count <= count + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (wr_ok) begin
                        state <= IDLE;
                        if ((|word_unk) && (unk_frames != {CNT_W{1'b1}}))
                            unk_frames <= unk_frames + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_pair_rx.sv
// Testbench for nibble_pair_rx: two instances share one stimulus stream,
// A with defaults (MSB-first, 8-bit counters) and B with LSB_FIRST=1, CNT_W=2.
module tb_nibble_pair_rx;

    logic clk = 1'b0;
    logic rst_n, s_valid, s_data, s_sof, word_ready;
    logic s_ready_a, word_valid_a, s_ready_b, word_valid_b;
    logic [0:1][0:3] word_a, unk_a, word_b, unk_b;
    logic [7:0] unk_frames_a, abort_cnt_a;
    logic [1:0] unk_frames_b, abort_cnt_b;

    int tests = 0;
    int fails = 0;
    int frame_no = 0;
    int exp_abort_a = 0, exp_abort_b = 0, exp_unkf_a = 0, exp_unkf_b = 0;
    logic [7:0] q_word_a[$], q_unk_a[$], q_word_b[$], q_unk_b[$];

    always #5 clk = ~clk;

    nibble_pair_rx #(.CNT_W(8), .LSB_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
        .s_ready(s_ready_a), .word(word_a), .word_unk(unk_a), .word_valid(word_valid_a),
        .word_ready(word_ready), .unk_frames(unk_frames_a), .abort_cnt(abort_cnt_a)
    );

    nibble_pair_rx #(.CNT_W(2), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
        .s_ready(s_ready_b), .word(word_b), .word_unk(unk_b), .word_valid(word_valid_b),
        .word_ready(word_ready), .unk_frames(unk_frames_b), .abort_cnt(abort_cnt_b)
    );

    // Arrival position p -> flat word bit (MSB of the flat word is element [0][0])
    function automatic logic [7:0] map_frame(logic [0:7] f, bit lsb);
        logic [7:0] r;
        r = '0;
        for (int p = 0; p < 8; p++) begin
            if (lsb) r[p] = f[p];
            else     r[7-p] = f[p];
        end
        return r;
    endfunction

    function automatic logic [0:7] unk_of(logic [0:7] f);
        logic [0:7] u;
        for (int p = 0; p < 8; p++) u[p] = $isunknown(f[p]);
        return u;
    endfunction

    function automatic int sat_inc(int v, int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(logic [0:7] f);
        q_word_a.push_back(map_frame(f, 1'b0));
        q_unk_a.push_back(map_frame(unk_of(f), 1'b0));
        q_word_b.push_back(map_frame(f, 1'b1));
        q_unk_b.push_back(map_frame(unk_of(f), 1'b1));
    endtask

    task automatic send_bit(logic sof, logic d);
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(logic [0:7] f);
        push_expected(f);
        for (int p = 0; p < 8; p++) send_bit(p == 0, f[p]);
    endtask

    // Waits (bounded) for a held frame, then pops and compares the scoreboard
    task automatic check_delivery(string tag);
        logic [7:0] ew_a, eu_a, ew_b, eu_b;
        int waited;
        waited = 0;
        while (word_valid_a !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk({tag, "_valid_a"}, 32'(word_valid_a), 32'd1);
        chk({tag, "_valid_b"}, 32'(word_valid_b), 32'd1);
        if (q_word_a.size() == 0) begin
            chk({tag, "_queue"}, 32'(q_word_a.size()), 32'd1);
        end else begin
            ew_a = q_word_a.pop_front();
            eu_a = q_unk_a.pop_front();
            ew_b = q_word_b.pop_front();
            eu_b = q_unk_b.pop_front();
            chk({tag, "_word_a"}, 32'(word_a), 32'(ew_a));
            chk({tag, "_unk_a"},  32'(unk_a),  32'(eu_a));
            chk({tag, "_word_b"}, 32'(word_b), 32'(ew_b));
            chk({tag, "_unk_b"},  32'(unk_b),  32'(eu_b));
            frame_no++;
            $display("[TB] frame %0d %s: word_a=%b unk_a=%b word_b=%b unk_b=%b",
                     frame_no, tag, word_a, unk_a, word_b, unk_b);
        end
    endtask

    // Completes the handshake and checks the return to IDLE and unk_frames
    task automatic release_frame(string tag, logic [0:7] f);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        if (|unk_of(f)) begin
            exp_unkf_a = sat_inc(exp_unkf_a, 255);
            exp_unkf_b = sat_inc(exp_unkf_b, 3);
        end
        chk({tag, "_drop_valid"}, 32'(word_valid_a), 32'd0);
        chk({tag, "_ready_back"}, 32'(s_ready_a), 32'd1);
        chk({tag, "_unkf_a"}, 32'(unk_frames_a), 32'(exp_unkf_a));
        chk({tag, "_unkf_b"}, 32'(unk_frames_b), 32'(exp_unkf_b));
    endtask

    initial begin
        logic [0:7] f1, f2, f3, f4, f5, f6;
        logic [7:0] held;
        f1 = 8'b1000_1111;
        f2 = 8'bzz11_x01z;
        f3 = 8'b0110_1010;
        f4 = 8'b0101_1100;
        f5 = 8'b1011_0011;
        f6 = 8'b1100_0110;

        rst_n = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_sof = 1'b0; word_ready = 1'b1;

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_word",   32'(word_a), 32'd0);
        chk("rst_unk",    32'(unk_a), 32'd0);
        chk("rst_valid",  32'(word_valid_a), 32'd0);
        chk("rst_ready",  32'(s_ready_a), 32'd1);
        chk("rst_unkf",   32'(unk_frames_a), 32'd0);
        chk("rst_abort",  32'(abort_cnt_a), 32'd0);
        chk("rst_ready_b", 32'(s_ready_b), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Bits without sof in IDLE are dropped
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("idle_drop_valid", 32'(word_valid_a), 32'd0);

        // Basic frame; word_valid the cycle after the 8th bit
        send_frame(f1);
        chk("f1_latency", 32'(word_valid_a), 32'd1);
        chk("f1_sready",  32'(s_ready_a), 32'd0);
        check_delivery("f1");
        release_frame("f1", f1);

        // Frame with x/z bits
        send_frame(f2);
        check_delivery("f2");
        chk("f2_elem00", 32'(word_a[0][0]), 32'(f2[0]));
        release_frame("f2", f2);

        // Abort after 5 bits, only the restarted frame is delivered
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'(i % 2));
        chk("abort_no_valid", 32'(word_valid_a), 32'd0);
        exp_abort_a = sat_inc(exp_abort_a, 255);
        exp_abort_b = sat_inc(exp_abort_b, 3);
        send_frame(f3);
        check_delivery("f3");
        chk("f3_queue_empty", 32'(q_word_a.size()), 32'd0);
        chk("f3_abort_a", 32'(abort_cnt_a), 32'(exp_abort_a));
        chk("f3_abort_b", 32'(abort_cnt_b), 32'(exp_abort_b));
        release_frame("f3", f3);

        // Consumer stall for 10 cycles with s_valid high
        word_ready = 1'b0;
        send_frame(f4);
        check_delivery("f4");
        held = word_a;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_sof   = 1'(i % 2);
            s_data  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("stall_sready", 32'(s_ready_a), 32'd0);
            chk("stall_word",   32'(word_a), 32'(held));
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        release_frame("f4", f4);

        // Five consecutive aborts: B's 2-bit counter must stick at 3
        send_bit(1'b1, f5[0]);
        send_bit(1'b0, f5[1]);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, f5[0]);
            send_bit(1'b0, f5[1]);
            exp_abort_a = sat_inc(exp_abort_a, 255);
            exp_abort_b = sat_inc(exp_abort_b, 3);
        end
        push_expected(f5);
        for (int p = 2; p < 8; p++) send_bit(1'b0, f5[p]);
        check_delivery("f5");
        chk("sat_abort_a", 32'(abort_cnt_a), 32'(exp_abort_a));
        chk("sat_abort_b", 32'(abort_cnt_b), 32'(exp_abort_b));
        release_frame("f5", f5);

        // Reset between clock edges in the middle of SHIFT
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(word_valid_a), 32'd0);
        chk("mid_rst_ready", 32'(s_ready_a), 32'd1);
        chk("mid_rst_abort", 32'(abort_cnt_a), 32'd0);
        chk("mid_rst_unkf",  32'(unk_frames_a), 32'd0);
        chk("mid_rst_word",  32'(word_a), 32'd0);
        exp_abort_a = 0; exp_abort_b = 0; exp_unkf_a = 0; exp_unkf_b = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Recovery frame after reset; counters stay at zero
        send_frame(f6);
        check_delivery("f6");
        chk("f6_abort_a", 32'(abort_cnt_a), 32'(exp_abort_a));
        release_frame("f6", f6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_pair_rx.md
NIBBLE_PAIR_RX -- requirements
Module: nibble_pair_rx

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the status counters.
REQ-002 SHALL have parameter LSB_FIRST, default 0: 0 = element [0][0] arrives first; 1 = element [1][3] arrives first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_valid, input, 1 bit: serial bit present.
REQ-006 SHALL have port s_data, input, 1 bit, 4-state logic: serial bit value; 0/1/x/z are all legal.
REQ-007 SHALL have port s_sof, input, 1 bit: start-of-frame; qualified by s_valid.
REQ-008 SHALL have port s_ready, output, 1 bit: receiver accepts a bit this cycle.
REQ-009 SHALL have port word, output, reg [0:1][0:3]: the assembled packed frame.
REQ-010 SHALL have port word_unk, output, [0:1][0:3]: per element, 1 where the received bit was x or z.
REQ-011 SHALL have port word_valid, output, 1 bit: frame held for the consumer.
REQ-012 SHALL have port word_ready, input, 1 bit: consumer takes the frame.
REQ-013 SHALL have port unk_frames, output, CNT_W bits: count of delivered frames with any unknown bit.
REQ-014 SHALL have port abort_cnt, output, CNT_W bits: count of frames restarted by s_sof mid-frame.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and HOLD; a bit is accepted when s_valid && s_ready.
REQ-016 IDLE: s_ready=1; bits without s_sof are dropped; an accepted bit with s_sof is stored as bit 0, count=1, next state SHIFT.
REQ-017 SHIFT: s_ready=1; each accepted bit is stored at position count and count increments; the 8th bit (count 7) moves the FSM to HOLD on that edge.
REQ-018 Position mapping SHALL be: position p maps to element [p/4][p%4] when LSB_FIRST=0, and to element [1-p/4][3-p%4] when LSB_FIRST=1.
REQ-019 Stored bits SHALL preserve 4-state values exactly (case-equality semantics); word_unk[i][j] SHALL be set when the stored bit is x or z.
REQ-020 An accepted s_sof in SHIFT SHALL discard the partial frame, clear word_unk, store the new bit as bit 0 with count=1, and increment abort_cnt.
REQ-021 HOLD: s_ready=0; word_valid=1; word and word_unk are stable; the FSM leaves HOLD on the edge where word_ready=1.
REQ-022 Leaving HOLD SHALL go to IDLE; there is no same-cycle acceptance of a new bit (s_ready is 0 in HOLD).
REQ-023 On a HOLD exit with a non-zero word_unk, unk_frames SHALL increment once.
REQ-024 Both counters SHALL saturate at 2**CNT_W-1 and SHALL NOT wrap.
REQ-025 Latency SHALL be: word_valid rises on the cycle after the 8th bit is accepted.
REQ-026 An x or z on s_valid, s_sof or word_ready SHALL be treated as 0.
REQ-027 word SHALL hold its last delivered value outside HOLD; word_unk SHALL clear on entry to SHIFT.

Reset
REQ-028 On rst_n low, the FSM SHALL enter IDLE immediately (asynchronously), regardless of the current state.
REQ-029 Reset values SHALL be: word=0, word_unk=0, word_valid=0, count=0, unk_frames=0, abort_cnt=0; s_ready=1 while in IDLE.
REQ-030 A reset asserted during SHIFT or HOLD SHALL discard the frame without incrementing any counter.

Verification
REQ-031 Send sof+bits 1,0,0,0,1,1,1,1 with LSB_FIRST=0 and word_ready=1 -> one cycle later word=8'b1000_1111, word_valid=1, word_unk=0; word_valid drops the next cycle.
REQ-032 Send the frame z,z,1,1,x,0,1,z -> word_unk=8'b1100_1001, word[0][0]===1'bz; after the handshake unk_frames=1.
REQ-033 Send 5 bits, then a new sof plus 8 bits -> abort_cnt=1; only the second frame is delivered.
REQ-034 Hold word_ready=0 for 10 cycles with s_valid=1 -> s_ready=0 throughout and word stays stable; after word_ready=1 the FSM is in IDLE.
REQ-035 Pull rst_n low mid-SHIFT, between clock edges -> word_valid=0 and s_ready=1 immediately; counters unchanged at 0.
REQ-036 Run with CNT_W=2 and 5 aborted frames -> abort_cnt saturates at 3.
